// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS-style core: opcodes, ALU control
// encodings (also used by the ALU), datapath select encodings and control states.
package mips16_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_BEQ   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_ORI   = 4'b0101;
  localparam logic [3:0] OP_SLTI  = 4'b0110;
  localparam logic [3:0] OP_J     = 4'b0111;

  localparam logic [2:0] FUNCT_ILLEGAL = 3'b101;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_EXEC_I    = 4'd8,
    ST_I_WB      = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
  } state_t;

  // Which flavour of ALU operation a state asks for.
  typedef enum logic [1:0] {
    CLS_ADD    = 2'd0,
    CLS_RTYPE  = 2'd1,
    CLS_ITYPE  = 2'd2,
    CLS_BRANCH = 2'd3
  } alu_class_t;

  // States that wait on mem_ready and therefore run the wait counter.
  function automatic logic is_mem_state(input state_t st);
    return (st == ST_FETCH) || (st == ST_MEM_READ) || (st == ST_MEM_WRITE);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational map of (ALU class, opcode, funct) to ALU control and illegal flag.
// Zero latency; no flow control.
module alu_op_decode
  import mips16_pkg::*;
(
  input  alu_class_t  i_cls,
  input  logic [3:0]  i_opcode,
  input  logic [2:0]  i_funct,
  output logic [2:0]  o_alu_ctrl,
  output logic        o_illegal
);

  alu_ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = ALU_ADD;
    case (i_cls)
      CLS_RTYPE: begin
        if (i_funct != FUNCT_ILLEGAL) w_ctrl = alu_ctrl_t'(i_funct);
      end
      CLS_ITYPE: begin
        case (i_opcode)
          OP_ORI:  w_ctrl = ALU_OR;
          OP_SLTI: w_ctrl = ALU_SLT;
          default: w_ctrl = ALU_ADD;
        endcase
      end
      CLS_BRANCH: w_ctrl = ALU_SUB;
      default:    w_ctrl = ALU_ADD;
    endcase
  end

  assign o_alu_ctrl = w_ctrl;
  assign o_illegal  = i_opcode[3] | ((i_opcode == OP_RTYPE) && (i_funct == FUNCT_ILLEGAL));

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory
// wait counter that aborts to FETCH after MEM_WAIT_MAX stalled cycles (0 = never).
module mc_control
  import mips16_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_timeout
);

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_wait_cnt;
  logic       w_timeout;
  logic       w_illegal;
  alu_class_t w_cls;
  logic [2:0] w_alu_ctrl;

  logic       w_pc_en, w_iord, w_mem_read, w_mem_write, w_ir_write;
  logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_pc_source;
  logic       w_illegal_op;

  // A ready memory in the limit cycle completes normally rather than aborting.
  assign w_timeout = (WAIT_MAX != 8'd0) && is_mem_state(r_state) && !mem_ready
                     && (r_wait_cnt == WAIT_MAX);

  always_comb begin
    case (r_state)
      ST_EXEC_R: w_cls = CLS_RTYPE;
      ST_EXEC_I: w_cls = CLS_ITYPE;
      ST_BRANCH: w_cls = CLS_BRANCH;
      default:   w_cls = CLS_ADD;
    endcase
  end

  alu_op_decode u_alu_op_decode (
    .i_cls      (w_cls),
    .i_opcode   (opcode),
    .i_funct    (funct),
    .o_alu_ctrl (w_alu_ctrl),
    .o_illegal  (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next_state;
  end

  // A FETCH abort stays in FETCH, so the timeout clears the counter explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_wait_cnt <= 8'd0;
    else if ((w_next_state != r_state) || w_timeout)  r_wait_cnt <= 8'd0;
    else if (is_mem_state(r_state) && !mem_ready)     r_wait_cnt <= r_wait_cnt + 8'd1;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready)      w_next_state = ST_DECODE;
        else if (w_timeout) w_next_state = ST_FETCH;
      end
      ST_DECODE: begin
        if (w_illegal) w_next_state = ST_FETCH;
        else begin
          case (opcode)
            OP_RTYPE:                 w_next_state = ST_EXEC_R;
            OP_LW, OP_SW:             w_next_state = ST_MEM_ADDR;
            OP_BEQ:                   w_next_state = ST_BRANCH;
            OP_ADDI, OP_ORI, OP_SLTI: w_next_state = ST_EXEC_I;
            OP_J:                     w_next_state = ST_JUMP;
            default:                  w_next_state = ST_FETCH;
          endcase
        end
      end
      ST_MEM_ADDR:  w_next_state = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ: begin
        if (mem_ready)      w_next_state = ST_MEM_WB;
        else if (w_timeout) w_next_state = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        if (mem_ready || w_timeout) w_next_state = ST_FETCH;
      end
      ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: w_next_state = ST_FETCH;
      ST_EXEC_R:    w_next_state = ST_R_WB;
      ST_EXEC_I:    w_next_state = ST_I_WB;
      default:      w_next_state = ST_FETCH;
    endcase
  end

  always_comb begin
    w_pc_en      = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_B;
    w_pc_source  = PCSRC_ALU;
    w_illegal_op = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_TWO;
        w_ir_write  = mem_ready;
        w_pc_en     = mem_ready;
      end
      ST_DECODE: begin
        w_alu_src_b  = SRCB_IMM_SH;
        w_illegal_op = w_illegal;
      end
      ST_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      ST_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      ST_EXEC_R: w_alu_src_a = 1'b1;
      ST_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      ST_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      ST_I_WB: w_reg_write = 1'b1;
      ST_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_pc_source = PCSRC_ALUOUT;
        w_pc_en     = zero;
      end
      ST_JUMP: begin
        w_pc_source = PCSRC_JUMP;
        w_pc_en     = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables and strobes are held low for the whole reset assertion.
  assign pc_en       = w_pc_en      & rst_n;
  assign ir_write    = w_ir_write   & rst_n;
  assign reg_write   = w_reg_write  & rst_n;
  assign mem_write   = w_mem_write  & rst_n;
  assign mem_read    = w_mem_read   & rst_n;
  assign illegal_op  = w_illegal_op & rst_n;
  assign mem_timeout = w_timeout    & rst_n;
  assign iord        = w_iord;
  assign reg_dst     = w_reg_dst;
  assign mem_to_reg  = w_mem_to_reg;
  assign alu_src_a   = w_alu_src_a;
  assign alu_src_b   = w_alu_src_b;
  assign alu_ctrl    = w_alu_ctrl;
  assign pc_source   = w_pc_source;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle comparison of all control outputs
// against hand-written per-state vectors.
module tb_mc_control;

  logic       clk, rst_n;
  logic [3:0] opcode;
  logic [2:0] funct;
  logic       zero, mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_ctrl;

  int n_pass = 0;
  int n_total = 0;

  mc_control #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_source(pc_source),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_en iord mem_read mem_write ir_write reg_write reg_dst mem_to_reg alu_src_a,
  //  alu_src_b, alu_ctrl, pc_source, illegal_op, mem_timeout}
  wire [17:0] obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
                     mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_source,
                     illegal_op, mem_timeout};

  localparam logic [17:0] E_RST   = {9'b000000000, 2'b01, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_FET_R = {9'b101010000, 2'b01, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_FET_W = {9'b001000000, 2'b01, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_DEC   = {9'b000000000, 2'b11, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_MADDR = {9'b000000001, 2'b10, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_MRD   = {9'b011000000, 2'b00, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_MWB   = {9'b000001010, 2'b00, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_MWR   = {9'b010100000, 2'b00, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_RWB   = {9'b000001100, 2'b00, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_IWB   = {9'b000001000, 2'b00, 3'b010, 2'b00, 2'b00};
  localparam logic [17:0] E_JMP   = {9'b100000000, 2'b00, 3'b010, 2'b10, 2'b00};
  localparam logic [17:0] B_ILL   = 18'b10;
  localparam logic [17:0] B_TO    = 18'b01;

  function automatic logic [17:0] e_exr(input logic [2:0] ac);
    return {9'b000000001, 2'b00, ac, 2'b00, 2'b00};
  endfunction
  function automatic logic [17:0] e_exi(input logic [2:0] ac);
    return {9'b000000001, 2'b10, ac, 2'b00, 2'b00};
  endfunction
  function automatic logic [17:0] e_br(input logic z);
    return {z, 8'b00000001, 2'b00, 3'b110, 2'b01, 2'b00};
  endfunction

  task automatic chk(input string tag, input logic [17:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Check the current cycle's outputs, then move to the next cycle.
  task automatic cyc(input string tag, input logic [17:0] exp);
    #1;
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'h0; funct = 3'b000; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("reset", E_RST);
    @(posedge clk); #1;
    chk("reset_held", E_RST);
    rst_n = 1'b1;
    #1;

    // ADD R-type
    opcode = 4'b0000; funct = 3'b010;
    cyc("add_fetch", E_FET_R);
    cyc("add_decode", E_DEC);
    cyc("add_exec", e_exr(3'b010));
    cyc("add_wb", E_RWB);

    // LW with three stalled MEM_READ cycles
    opcode = 4'b0001;
    cyc("lw_fetch", E_FET_R);
    cyc("lw_decode", E_DEC);
    cyc("lw_addr", E_MADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("lw_wait%0d", i), E_MRD);
    mem_ready = 1'b1;
    cyc("lw_read", E_MRD);
    cyc("lw_wb", E_MWB);

    // BEQ taken, then not taken
    opcode = 4'b0011; zero = 1'b1;
    cyc("beq1_fetch", E_FET_R);
    cyc("beq1_decode", E_DEC);
    cyc("beq1_branch", e_br(1'b1));
    zero = 1'b0;
    cyc("beq0_fetch", E_FET_R);
    cyc("beq0_decode", E_DEC);
    cyc("beq0_branch", e_br(1'b0));

    // Illegal opcode, then illegal funct
    opcode = 4'b1010;
    cyc("illop_fetch", E_FET_R);
    cyc("illop_decode", E_DEC | B_ILL);
    opcode = 4'b0000; funct = 3'b101;
    cyc("illfn_fetch", E_FET_R);
    cyc("illfn_decode", E_DEC | B_ILL);
    funct = 3'b000;

    // SW never ready: abort in the 16th MEM_WRITE cycle
    opcode = 4'b0010;
    cyc("sw1_fetch", E_FET_R);
    cyc("sw1_decode", E_DEC);
    cyc("sw1_addr", E_MADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc($sformatf("sw1_wait%0d", i), E_MWR);
    cyc("sw1_timeout", E_MWR | B_TO);
    mem_ready = 1'b1;
    // SW ready exactly in the limit cycle: completes normally
    cyc("sw2_fetch", E_FET_R);
    cyc("sw2_decode", E_DEC);
    cyc("sw2_addr", E_MADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc($sformatf("sw2_wait%0d", i), E_MWR);
    mem_ready = 1'b1;
    cyc("sw2_done", E_MWR);

    // FETCH timeout re-fetches without loading the PC
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc($sformatf("fet_wait%0d", i), E_FET_W);
    cyc("fet_timeout", E_FET_W | B_TO);
    cyc("fet_refetch", E_FET_W);
    mem_ready = 1'b1;

    // I-type ALU ops and jump
    opcode = 4'b0100;
    cyc("addi_fetch", E_FET_R);
    cyc("addi_decode", E_DEC);
    cyc("addi_exec", e_exi(3'b010));
    cyc("addi_wb", E_IWB);
    opcode = 4'b0101;
    cyc("ori_fetch", E_FET_R);
    cyc("ori_decode", E_DEC);
    cyc("ori_exec", e_exi(3'b001));
    cyc("ori_wb", E_IWB);
    opcode = 4'b0110;
    cyc("slti_fetch", E_FET_R);
    cyc("slti_decode", E_DEC);
    cyc("slti_exec", e_exi(3'b111));
    cyc("slti_wb", E_IWB);
    opcode = 4'b0111;
    cyc("j_fetch", E_FET_R);
    cyc("j_decode", E_DEC);
    cyc("j_jump", E_JMP);

    // Reset asserted in the middle of EXEC_R
    opcode = 4'b0000; funct = 3'b110;
    cyc("sub_fetch", E_FET_R);
    cyc("sub_decode", E_DEC);
    #1;
    chk("sub_exec", e_exr(3'b110));
    rst_n = 1'b0;
    #1;
    chk("midrst_now", E_RST);
    @(posedge clk); #1;
    chk("midrst_held", E_RST);
    rst_n = 1'b1;
    cyc("post_rst_fetch", E_FET_R);
    cyc("post_rst_decode", E_DEC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
